// File: rtl/proc_ctrl_fsm.sv
// proc_ctrl_fsm: multi-cycle control unit for the 10-bit single-bus datapath.
// Optional feature macro: PROC_CTRL_PEEK_EN (register peek from idle state).
module proc_ctrl_fsm #(
    parameter int W    = 10,
    parameter int NREG = 4
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [W-1:0]    DIN,
    input  logic            Run,
    input  logic            Peek,
    output logic [NREG-1:0] Rin,
    output logic [NREG-1:0] Rout,
    output logic            ExtrnOut,
    output logic            Ain,
    output logic            Gin,
    output logic            Gout,
    output logic [2:0]      ALUop,
    output logic            PeekOut,
    output logic [1:0]      Tstep,
    output logic            Done
);

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [W-1:0]   ir;
    logic [3:0]     opc;
    logic [1:0]     rx;
    logic [1:0]     ry;
    logic           is_alu;
    logic           is_not;
    logic [2:0]     alu_sel;

    assign opc    = ir[W-1 -: 4];
    assign rx     = ir[W-5 -: 2];
    assign ry     = ir[W-7 -: 2];
    assign is_alu = (opc >= 4'd2) && (opc <= 4'd5);
    assign is_not = (opc == 4'd6);
    assign Tstep  = state;

    // Low IR bits carry no meaning.
    wire unused_ir = ^ir[W-9:0];
`ifndef PROC_CTRL_PEEK_EN
    wire unused_peek = Peek;
`endif

    function automatic logic [NREG-1:0] onehot(input logic [1:0] idx);
        logic [NREG-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // State and instruction register; IR only captures in idle with Run.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= T0;
            ir    <= '0;
        end else begin
            state <= state_nxt;
            if (state == T0 && Run)
                ir <= DIN;
        end
    end

    // Next-state: ALU and NOT take the three-step path, others finish in T1.
    always_comb begin
        state_nxt = state;
        case (state)
            T0:      state_nxt = Run ? T1 : T0;
            T1:      state_nxt = (is_alu || is_not) ? T2 : T0;
            T2:      state_nxt = T3;
            T3:      state_nxt = T0;
            default: state_nxt = T0;
        endcase
    end

    // ALU operation select from the opcode; NOT is the fallback.
    always_comb begin
        alu_sel = 3'd4;
        case (opc)
            4'd2:    alu_sel = 3'd0;
            4'd3:    alu_sel = 3'd1;
            4'd4:    alu_sel = 3'd2;
            4'd5:    alu_sel = 3'd3;
            default: alu_sel = 3'd4;
        endcase
    end

    // Control outputs decoded from state and IR; one bus driver at most.
    always_comb begin
        Rin      = '0;
        Rout     = '0;
        ExtrnOut = 1'b0;
        Ain      = 1'b0;
        Gin      = 1'b0;
        Gout     = 1'b0;
        ALUop    = 3'd0;
        PeekOut  = 1'b0;
        Done     = 1'b0;
        case (state)
            T0: begin
`ifdef PROC_CTRL_PEEK_EN
                if (!Run && Peek) begin
                    Rout    = onehot(DIN[1:0]);
                    PeekOut = 1'b1;
                end
`endif
            end
            T1: begin
                if (opc == 4'd0) begin
                    ExtrnOut = 1'b1;
                    Rin      = onehot(rx);
                    Done     = 1'b1;
                end else if (opc == 4'd1) begin
                    Rout = onehot(ry);
                    Rin  = onehot(rx);
                    Done = 1'b1;
                end else if (is_alu || is_not) begin
                    Rout = onehot(rx);
                    Ain  = 1'b1;
                end else begin
                    Done = 1'b1;
                end
            end
            T2: begin
                Gin   = 1'b1;
                ALUop = alu_sel;
                if (is_alu)
                    Rout = onehot(ry);
            end
            T3: begin
                Gout = 1'b1;
                Rin  = onehot(rx);
                Done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_proc_ctrl_fsm.sv
// tb_proc_ctrl_fsm: directed self-checking bench for proc_ctrl_fsm.
// Outputs are packed into one vector and compared against hand-built values.
module tb_proc_ctrl_fsm;

    logic       CLK = 1'b0;
    logic       RST;
    logic [9:0] DIN;
    logic       Run;
    logic       Peek;
    logic [3:0] Rin;
    logic [3:0] Rout;
    logic       ExtrnOut;
    logic       Ain;
    logic       Gin;
    logic       Gout;
    logic [2:0] ALUop;
    logic       PeekOut;
    logic [1:0] Tstep;
    logic       Done;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [18:0] exp_v;
    logic [18:0] obs;

    proc_ctrl_fsm #(.W(10), .NREG(4)) dut (
        .CLK(CLK), .RST(RST), .DIN(DIN), .Run(Run), .Peek(Peek),
        .Rin(Rin), .Rout(Rout), .ExtrnOut(ExtrnOut), .Ain(Ain),
        .Gin(Gin), .Gout(Gout), .ALUop(ALUop), .PeekOut(PeekOut),
        .Tstep(Tstep), .Done(Done)
    );

    always #5 CLK = ~CLK;

    assign obs = {Rin, Rout, ExtrnOut, Ain, Gin, Gout,
                  ALUop, PeekOut, Tstep, Done};

    function automatic logic [18:0] ev(
        input logic [3:0] rin, input logic [3:0] rout,
        input logic ext, input logic ain, input logic gin,
        input logic gout, input logic [2:0] op, input logic pk,
        input logic [1:0] t, input logic dn);
        return {rin, rout, ext, ain, gin, gout, op, pk, t, dn};
    endfunction

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    task automatic test_reset();
        RST = 1'b1; Run = 1'b1; Peek = 1'b0;
        DIN = 10'b0000_10_0000;
        for (int i = 0; i < 3; i++) begin
            step();
            exp_v = '0;
            total_cnt++;
            if (obs !== exp_v)
                $display("FAIL reset_%0d: got %h want %h", i, obs, exp_v);
            else pass_cnt++;
        end
        Run = 1'b0;
        RST = 1'b0;
        step();
        exp_v = '0;
        total_cnt++;
        if (obs !== exp_v)
            $display("FAIL reset_release: got %h want %h", obs, exp_v);
        else pass_cnt++;
    endtask

    task automatic test_load();
        DIN = 10'b0000_10_0000; Run = 1'b1;
        step();
        Run = 1'b0;
        exp_v = ev(4'b0100, 4'b0, 1, 0, 0, 0, 3'd0, 0, 2'd1, 1);
        total_cnt++;
        if (obs !== exp_v)
            $display("FAIL load_t1: got %h want %h", obs, exp_v);
        else pass_cnt++;
        step();
        exp_v = '0;
        total_cnt++;
        if (obs !== exp_v)
            $display("FAIL load_t0: got %h want %h", obs, exp_v);
        else pass_cnt++;
    endtask

    task automatic test_mov();
        DIN = 10'b0001_00_10_00; Run = 1'b1;
        step();
        Run = 1'b0;
        DIN = 10'b0000_11_0000;
        exp_v = ev(4'b0001, 4'b0100, 0, 0, 0, 0, 3'd0, 0, 2'd1, 1);
        total_cnt++;
        if (obs !== exp_v)
            $display("FAIL mov_t1: got %h want %h", obs, exp_v);
        else pass_cnt++;
        step();
        exp_v = '0;
        total_cnt++;
        if (obs !== exp_v)
            $display("FAIL mov_t0: got %h want %h", obs, exp_v);
        else pass_cnt++;
    endtask

    task automatic test_add();
        DIN = 10'b0010_01_11_00; Run = 1'b1;
        step();
        Run = 1'b0;
        exp_v = ev(4'b0, 4'b0010, 0, 1, 0, 0, 3'd0, 0, 2'd1, 0);
        total_cnt++;
        if (obs !== exp_v)
            $display("FAIL add_t1: got %h want %h", obs, exp_v);
        else pass_cnt++;
        step();
        exp_v = ev(4'b0, 4'b1000, 0, 0, 1, 0, 3'd0, 0, 2'd2, 0);
        total_cnt++;
        if (obs !== exp_v)
            $display("FAIL add_t2: got %h want %h", obs, exp_v);
        else pass_cnt++;
        step();
        exp_v = ev(4'b0010, 4'b0, 0, 0, 0, 1, 3'd0, 0, 2'd3, 1);
        total_cnt++;
        if (obs !== exp_v)
            $display("FAIL add_t3: got %h want %h", obs, exp_v);
        else pass_cnt++;
        total_cnt++;
        if ($countones({ExtrnOut, Rout, Gout}) > 1)
            $display("FAIL add_bus: got %0d drivers want <=1",
                     $countones({ExtrnOut, Rout, Gout}));
        else pass_cnt++;
        step();
        exp_v = '0;
        total_cnt++;
        if (obs !== exp_v)
            $display("FAIL add_t0: got %h want %h", obs, exp_v);
        else pass_cnt++;
    endtask

    task automatic test_alu_ops();
        logic [3:0] op;
        logic [2:0] sel;
        for (int k = 3; k <= 6; k++) begin
            op  = 4'(k);
            sel = (k == 6) ? 3'd4 : 3'(k - 2);
            DIN = {op, 2'b10, 2'b00, 2'b00}; Run = 1'b1;
            step();
            Run = 1'b0;
            DIN = 10'h3FF;
            exp_v = ev(4'b0, 4'b0100, 0, 1, 0, 0, 3'd0, 0, 2'd1, 0);
            total_cnt++;
            if (obs !== exp_v)
                $display("FAIL alu%0d_t1: got %h want %h", k, obs, exp_v);
            else pass_cnt++;
            step();
            exp_v = ev(4'b0, (k == 6) ? 4'b0 : 4'b0001, 0, 0, 1, 0,
                       sel, 0, 2'd2, 0);
            total_cnt++;
            if (obs !== exp_v)
                $display("FAIL alu%0d_t2: got %h want %h", k, obs, exp_v);
            else pass_cnt++;
            step();
            exp_v = ev(4'b0100, 4'b0, 0, 0, 0, 1, 3'd0, 0, 2'd3, 1);
            total_cnt++;
            if (obs !== exp_v)
                $display("FAIL alu%0d_t3: got %h want %h", k, obs, exp_v);
            else pass_cnt++;
            step();
        end
    endtask

    task automatic test_undefined();
        DIN = 10'b1111_00_00_00; Run = 1'b1;
        step();
        Run = 1'b0;
        exp_v = ev(4'b0, 4'b0, 0, 0, 0, 0, 3'd0, 0, 2'd1, 1);
        total_cnt++;
        if (obs !== exp_v)
            $display("FAIL undef_t1: got %h want %h", obs, exp_v);
        else pass_cnt++;
        DIN = 10'b0111_11_11_00; Run = 1'b1;
        step();
        step();
        Run = 1'b0;
        exp_v = ev(4'b0, 4'b0, 0, 0, 0, 0, 3'd0, 0, 2'd1, 1);
        total_cnt++;
        if (obs !== exp_v)
            $display("FAIL undef7_t1: got %h want %h", obs, exp_v);
        else pass_cnt++;
        step();
    endtask

    task automatic test_back_to_back();
        DIN = 10'b0000_11_0000; Run = 1'b1;
        step();
        DIN = 10'b0001_01_00_00;
        #1;
        exp_v = ev(4'b1000, 4'b0, 1, 0, 0, 0, 3'd0, 0, 2'd1, 1);
        total_cnt++;
        if (obs !== exp_v)
            $display("FAIL b2b_hold: got %h want %h", obs, exp_v);
        else pass_cnt++;
        step();
        exp_v = '0;
        total_cnt++;
        if (obs !== exp_v)
            $display("FAIL b2b_t0: got %h want %h", obs, exp_v);
        else pass_cnt++;
        step();
        Run = 1'b0;
        exp_v = ev(4'b0010, 4'b0001, 0, 0, 0, 0, 3'd0, 0, 2'd1, 1);
        total_cnt++;
        if (obs !== exp_v)
            $display("FAIL b2b_mov: got %h want %h", obs, exp_v);
        else pass_cnt++;
        step();
    endtask

    task automatic test_reset_mid();
        DIN = 10'b0011_01_10_00; Run = 1'b1;
        step();
        Run = 1'b0;
        step();
        total_cnt++;
        if (Tstep !== 2'd2)
            $display("FAIL mid_pre: got %0d want 2", Tstep);
        else pass_cnt++;
        RST = 1'b1;
        #1;
        exp_v = '0;
        total_cnt++;
        if (obs !== exp_v)
            $display("FAIL mid_async: got %h want %h", obs, exp_v);
        else pass_cnt++;
        step();
        RST = 1'b0;
        step();
        exp_v = '0;
        total_cnt++;
        if (obs !== exp_v)
            $display("FAIL mid_idle: got %h want %h", obs, exp_v);
        else pass_cnt++;
        DIN = 10'b0000_01_0000; Run = 1'b1;
        step();
        Run = 1'b0;
        exp_v = ev(4'b0010, 4'b0, 1, 0, 0, 0, 3'd0, 0, 2'd1, 1);
        total_cnt++;
        if (obs !== exp_v)
            $display("FAIL mid_load: got %h want %h", obs, exp_v);
        else pass_cnt++;
        step();
    endtask

    task automatic test_peek();
        DIN = 10'b0000_00_00_11; Run = 1'b0; Peek = 1'b1;
        #1;
`ifdef PROC_CTRL_PEEK_EN
        exp_v = ev(4'b0, 4'b1000, 0, 0, 0, 0, 3'd0, 1, 2'd0, 0);
`else
        exp_v = '0;
`endif
        total_cnt++;
        if (obs !== exp_v)
            $display("FAIL peek_t0: got %h want %h", obs, exp_v);
        else pass_cnt++;
        step();
        total_cnt++;
        if (obs !== exp_v)
            $display("FAIL peek_stay: got %h want %h", obs, exp_v);
        else pass_cnt++;
        Run = 1'b1;
        #1;
        exp_v = '0;
        total_cnt++;
        if (obs !== exp_v)
            $display("FAIL peek_prio: got %h want %h", obs, exp_v);
        else pass_cnt++;
        step();
        Run = 1'b0;
        exp_v = ev(4'b0001, 4'b0, 1, 0, 0, 0, 3'd0, 0, 2'd1, 1);
        total_cnt++;
        if (obs !== exp_v)
            $display("FAIL peek_t1: got %h want %h", obs, exp_v);
        else pass_cnt++;
        Peek = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_load();
        test_mov();
        test_add();
        test_alu_ops();
        test_undefined();
        test_back_to_back();
        test_reset_mid();
        test_peek();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/proc_ctrl_fsm.md
# proc_ctrl_fsm

- Multi-cycle control unit for the 10-bit single-bus datapath.
- Latches an instruction from the switch input into an internal instruction register (IR), then steps through timesteps T0–T3.
- In each timestep it drives the bus-driver enables, register-load enables and ALU operation select for the register file, A register, G register and ALU.
- Sits between the debounced manual clock and the datapath. It also reports the current timestep for the HEX5 display and raises `Done`.

## Interface
- `W`, default 10: data/instruction width.
- `NREG`, default 4: number of general registers; register index is 2 bits.
- `CLK`, input, 1: debounced manual clock; all state changes on its rising edge.
- `RST`, input, 1: asynchronous, active-high reset.
- `DIN`, input, W: switch bus; sampled into IR at T0.
- `Run`, input, 1: level; start an instruction when sampled high in T0.
- `Peek`, input, 1: debounced peek key, active-high; used only with the `PEEK_EN` macro.
- `Rin`, output, NREG: one-hot register load enables.
- `Rout`, output, NREG: one-hot register bus-drive enables.
- `ExtrnOut`, output, 1: drive `DIN` onto the bus.
- `Ain`, `Gin`, `Gout`, outputs, 1 each: load A, load G, drive G onto the bus.
- `ALUop`, output, 3: 0=ADD, 1=SUB, 2=XOR, 3=AND, 4=NOT(A).
- `PeekOut`, output, 1: the bus value is a peek and should be latched to the LEDs.
- `Tstep`, output, 2: current timestep, 0–3.
- `Done`, output, 1: the final step of the instruction is active.

## Operation
- IR fields: IR[9:6] = opcode, IR[5:4] = Rx, IR[3:2] = Ry, IR[1:0] ignored.
- States T0, T1, T2, T3. Tstep encodes the state.
- Outputs are combinational decodes of the state and IR. Every unlisted output is 0.

T0 (idle):
- If `Run`=1: IR <= DIN, next state T1.
- Otherwise stay in T0.

Opcode 0000, LOAD Rx:
- T1: ExtrnOut, Rin[Rx], Done.
- Then T0.

Opcode 0001, MOV Rx,Ry:
- T1: Rout[Ry], Rin[Rx], Done.
- Then T0.

Opcodes 0010 ADD, 0011 SUB, 0100 XOR, 0101 AND (Rx <= Rx op Ry):
- T1: Rout[Rx], Ain.
- T2: Rout[Ry], Gin, ALUop per opcode.
- T3: Gout, Rin[Rx], Done.
- Then T0.

Opcode 0110, NOT Rx:
- T1: Rout[Rx], Ain.
- T2: Gin, ALUop=4, no bus driver.
- T3: Gout, Rin[Rx], Done.

Opcodes 0111–1111 (undefined):
- T1: Done only, no loads.
- Then T0. No register changes.

Rules:
- Bus rule: at most one of `ExtrnOut`, any `Rout` bit, `Gout` is high in any state.
- `Rin` and `Rout` are each one-hot or all-zero.
- `Run` is level-sensitive. If `Run` is still high in T0 after `Done`, the next edge loads a new instruction.
- IR is held constant from T1 through the final step.

## Timing
- Reset values: state T0, IR=0, `Tstep`=0. All outputs are 0, including `Done` and `PeekOut`.
- Latency from the `Run` edge in T0 to `Done`: 1 cycle for LOAD, MOV and undefined opcodes; 3 cycles for ALU ops.
- A new instruction can be accepted on the edge immediately after the `Done` cycle.
- Datapath registers load on the same edge that leaves the step in which their enable was asserted.
- RST mid-instruction forces T0 and IR=0 immediately, asynchronously. The outputs drop to 0 in the same instant; the partial instruction has no further effect.
- `DIN` changes outside T0 do not affect IR. For LOAD, `DIN` in T1 is the value written.

## Configuration
- Macro: `PROC_CTRL_PEEK_EN`.
- Defined:
  - In T0 with `Run`=0 and `Peek`=1, assert `Rout[DIN[1:0]]` and `PeekOut`. The state stays T0.
  - `Run`=1 has priority over `Peek`.
  - `Peek` is ignored in T1–T3.
- Undefined:
  - `Peek` is ignored.
  - `PeekOut` is tied to 0.
  - All outputs are 0 in T0.

## Test plan
- Reset check: assert RST with `Run`=1 and clock running. Required: `Tstep`=0, IR=0, all enables 0 and `Done`=0 until RST is released.
- LOAD: `DIN`=10'b0000_10_0000, `Run`=1, clock once. Required: `Tstep`=1; `ExtrnOut`=1, `Rin`=4'b0100, `Done`=1; the next edge returns to `Tstep`=0.
- ADD: `DIN`=10'b0010_01_11_00. Required:
  - T1: `Rout`=0010, `Ain`=1.
  - T2: `Rout`=1000, `Gin`=1, `ALUop`=0.
  - T3: `Gout`=1, `Rin`=0010, `Done`=1.
  - Bus rule holds every cycle.
- Undefined opcode: `DIN`=10'b1111_00_00_00. Required: T1 with `Done`=1 only; `Rin`, `Ain` and `Gin` stay 0.
- Reset mid-operation: assert RST during T2 of a SUB. Required: immediate T0 with all outputs 0; after release, a LOAD executes normally.
- Peek (with `PROC_CTRL_PEEK_EN` defined): in T0, `Run`=0, `Peek`=1, `DIN[1:0]`=2'b11. Required: `Rout`=1000, `PeekOut`=1, `Tstep` stays 0. Then `Run`=1 with `Peek`=1: the IR loads and `PeekOut`=0.
